// File: rtl/qnigma_fifo_arb.sv
// Round-robin packet arbiter feeding one dual-clock FIFO write port.
// Optional stall watchdog enabled by defining QNIGMA_FIFO_ARB_TIMEOUT_EN.
module qnigma_fifo_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_write,
  output logic [DATA_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic {IDLE, OWN} state_t;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("qnigma_fifo_arb: N_REQ must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("qnigma_fifo_arb: TIMEOUT must be 1..65535");
  end

  state_t           state;
  logic [IW-1:0]    g;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    next_g;
  logic [IW-1:0]    pick_idle;
  logic [IW-1:0]    pick_b2b;
  logic [N_REQ-1:0] others;
  logic             xfer;
  logic             pkt_end;
  logic             hit;

  // Rotate the request vector so bit 0 is the base index, take the lowest set bit, un-rotate.
  function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] vec, input logic [IW-1:0] base);
    logic [N_REQ-1:0] rot;
    logic [IW:0]      sum;
    logic [IW-1:0]    pick;
    rot  = N_REQ'({vec, vec} >> base);
    pick = base;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, base} + (IW+1)'(k);
        if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
        pick = sum[IW-1:0];
      end
    end
    return pick;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign next_g       = (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
  assign others       = req_valid & ~grant;
  assign pick_idle    = rr_pick(req_valid, ptr);
  assign pick_b2b     = rr_pick(others, next_g);
  // grant is all-zero in IDLE, so it doubles as the owner mask for ready and write.
  assign xfer         = (|(grant & req_valid)) && !fifo_full && !hit;
  assign fifo_write   = xfer;
  assign req_ready    = (fifo_full || hit) ? '0 : grant;
  assign fifo_data_in = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  assign pkt_end      = xfer && req_last[g];
  assign busy         = (state == OWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state <= OWN;
            g     <= pick_idle;
            grant <= onehot(pick_idle);
          end
        end
        OWN: begin
          if (hit) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= next_g;
          end else if (pkt_end) begin
            ptr <= next_g;
            if (|others) begin
              g     <= pick_b2b;
              grant <= onehot(pick_b2b);
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef QNIGMA_FIFO_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;

  assign hit = (state == OWN) && (stall_cnt == 16'(TIMEOUT));

  // Counts owner-idle cycles; a full FIFO is not the owner's fault, so the count freezes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE || xfer || hit) begin
        stall_cnt <= '0;
      end else if (!req_valid[g] && !fifo_full) begin
        stall_cnt <= stall_cnt + 16'd1;
        if (stall_cnt + 16'd1 == 16'(TIMEOUT)) timeout_err <= 1'b1;
      end
    end
  end
`else
  assign hit         = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_qnigma_fifo_arb.sv
// Randomized bench for qnigma_fifo_arb against a cycle-level round-robin reference model.
module tb_qnigma_fifo_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef QNIGMA_FIFO_ARB_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_write;
  logic [DW-1:0]   fifo_data_in;
  logic            fifo_full;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout_err;

  always #5 clk = ~clk;

  qnigma_fifo_arb #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_write(fifo_write),
    .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .grant(grant),
    .busy(busy), .timeout_err(timeout_err)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: owner index (-1 = idle), round-robin pointer, stall count, error pulse.
  int owner = -1;
  int ptr   = 0;
  int cnt   = 0;
  bit err   = 1'b0;

  // Requester-side packet generators.
  int active[N];
  int len[N];
  int idx[N];
  int seq[N];
  int hold[N];
  int full_left  = 0;
  int wr_count   = 0;
  int busy_count = 0;
  int err_count  = 0;

  function automatic int rr(input logic [N-1:0] v, input int base);
    for (int k = 0; k < N; k++) begin
      if (v[(base + k) % N]) return (base + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] wordOf(input int i);
    return {8'(i + 1), 8'(seq[i]), 16'(idx[i])};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, check outputs, advance the model.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_ready;
    logic [N-1:0] oth;
    logic         exp_write;
    logic         t_hit;
    bit           new_err;
    int           o;
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = wordOf(i);
    #1;
    t_hit     = WD && (owner >= 0) && (cnt == TO);
    exp_grant = '0;
    if (owner >= 0) exp_grant[owner] = 1'b1;
    exp_write = (owner >= 0) && v[owner] && !f && !t_hit;
    exp_ready = (!f && !t_hit) ? exp_grant : '0;
    checkOutput("grant", 64'(grant), 64'(exp_grant));
    checkOutput("busy", 64'(busy), 64'(owner >= 0));
    checkOutput("ready", 64'(req_ready), 64'(exp_ready));
    checkOutput("write", 64'(fifo_write), 64'(exp_write));
    checkOutput("terr", 64'(timeout_err), 64'(err));
    if (exp_write) checkOutput("data", 64'(fifo_data_in), 64'(wordOf(owner)));
    if (fifo_write) wr_count++;
    if (busy) busy_count++;
    if (timeout_err) err_count++;
    @(posedge clk);
    new_err = 1'b0;
    if (owner < 0) begin
      if (|v) owner = rr(v, ptr);
      cnt = 0;
    end else begin
      o = owner;
      if (t_hit) begin
        owner = -1;
        ptr   = (o + 1) % N;
        cnt   = 0;
      end else if (exp_write && l[o]) begin
        ptr    = (o + 1) % N;
        oth    = v;
        oth[o] = 1'b0;
        owner  = rr(oth, ptr);
        cnt    = 0;
      end else if (exp_write) begin
        cnt = 0;
      end else if (!v[o] && !f) begin
        cnt++;
        if (WD && cnt == TO) new_err = 1'b1;
      end
    end
    err = new_err;
    for (int i = 0; i < N; i++) begin
      if (v[i] && exp_ready[i]) begin
        if (l[i]) active[i] = 0;
        else idx[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic stimCycle(input logic f);
    logic [N-1:0] v;
    logic [N-1:0] l;
    for (int i = 0; i < N; i++) begin
      v[i] = (active[i] != 0) && (hold[i] == 0);
      l[i] = (idx[i] == len[i] - 1);
      if (hold[i] > 0) hold[i]--;
    end
    applyStimulus(v, l, f);
  endtask

  task automatic startPkt(input int i, input int n);
    active[i] = 1;
    len[i]    = n;
    idx[i]    = 0;
    seq[i]++;
  endtask

  // Asserted at a falling edge; outputs must collapse at once and stay quiet while held.
  task automatic doReset(input int cyc);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_write", 64'(fifo_write), 64'd0);
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_terr", 64'(timeout_err), 64'd0);
    owner = -1; ptr = 0; cnt = 0; err = 1'b0;
    for (int i = 0; i < N; i++) begin active[i] = 0; hold[i] = 0; end
    repeat (cyc) begin
      @(posedge clk);
      #1 checkOutput("rst_hold_write", 64'(fifo_write), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin active[i] = 0; len[i] = 1; idx[i] = 0; seq[i] = 0; hold[i] = 0; end
    @(negedge clk);
    doReset(2);

    // Single one-word packet from requester 2, then pointer must sit at 3.
    startPkt(2, 1);
    stimCycle(1'b0);
    checkOutput("d_single_grant", 64'(grant), 64'b0100);
    wr_count = 0;
    stimCycle(1'b0);
    checkOutput("d_single_writes", 64'(wr_count), 64'd1);
    checkOutput("d_single_idle", 64'(grant), 64'd0);
    startPkt(0, 1);
    startPkt(3, 1);
    stimCycle(1'b0);
    checkOutput("d_ptr3_grant", 64'(grant), 64'b1000);
    stimCycle(1'b0);
    checkOutput("d_b2b_grant", 64'(grant), 64'b0001);
    stimCycle(1'b0);

    // Mid-packet reset with pointer at 1; arbitration must restart at index 0.
    startPkt(2, 3);
    stimCycle(1'b0);
    stimCycle(1'b0);
    doReset(2);
    startPkt(0, 1);
    startPkt(3, 1);
    stimCycle(1'b0);
    checkOutput("d_rst_restart", 64'(grant), 64'b0001);
    repeat (3) stimCycle(1'b0);

    // All four requesters, 3-word packets, FIFO never full.
    doReset(1);
    for (int i = 0; i < N; i++) startPkt(i, 3);
    stimCycle(1'b0);
    wr_count = 0; busy_count = 0;
    repeat (12) stimCycle(1'b0);
    checkOutput("d_all4_writes", 64'(wr_count), 64'd12);
    checkOutput("d_all4_busy", 64'(busy_count), 64'd12);
    checkOutput("d_all4_idle", 64'(grant), 64'd0);

    // FIFO full for 5 cycles mid-packet.
    startPkt(1, 3);
    stimCycle(1'b0);
    wr_count = 0;
    stimCycle(1'b0);
    repeat (5) stimCycle(1'b1);
    checkOutput("d_full_grant", 64'(grant), 64'b0010);
    stimCycle(1'b0);
    stimCycle(1'b0);
    checkOutput("d_full_writes", 64'(wr_count), 64'd3);

    // Requester 0 arrives while requester 1 owns; it must wait for req_last.
    startPkt(1, 3);
    stimCycle(1'b0);
    stimCycle(1'b0);
    startPkt(0, 1);
    stimCycle(1'b0);
    checkOutput("d_wait_grant", 64'(grant), 64'b0010);
    stimCycle(1'b0);
    checkOutput("d_next_grant", 64'(grant), 64'b0001);
    repeat (2) stimCycle(1'b0);

    // Owner stalls well beyond TIMEOUT after its first word.
    doReset(1);
    startPkt(0, 3);
    startPkt(1, 1);
    stimCycle(1'b0);
    stimCycle(1'b0);
    hold[0] = TO + 4;
    err_count = 0;
    repeat (TO + 3) stimCycle(1'b0);
    checkOutput("d_to_pulses", 64'(err_count), WD ? 64'd1 : 64'd0);
    checkOutput("d_to_grant", 64'(grant), WD ? 64'b0000 : 64'b0001);
    repeat (8) stimCycle(1'b0);

    // Randomized traffic with stalls, full bursts, long holds and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 400) == 0) doReset($urandom_range(1, 3));
      for (int i = 0; i < N; i++)
        if (active[i] == 0 && $urandom_range(0, 3) == 0) startPkt(i, $urandom_range(1, 4));
      for (int i = 0; i < N; i++)
        if (active[i] != 0 && hold[i] == 0 && $urandom_range(0, 7) == 0) hold[i] = 1;
      if (owner >= 0 && $urandom_range(0, 80) == 0) hold[owner] = TO + 3;
      if (full_left == 0 && $urandom_range(0, 50) == 0) full_left = 5;
      if (full_left > 0) begin
        full_left--;
        stimCycle(1'b1);
      end else begin
        stimCycle($urandom_range(0, 4) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
